// File: rtl/io_ctrl_wb.sv
// io_ctrl_wb: decides per pad whether the user core or a Wishbone
// GPIO register set drives it; also syncs inputs and flags rising edges.
module io_ctrl_wb #(
  parameter int          NUM_IO      = 38,
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000
) (
  input  logic              wb_clk_i,
  input  logic              rst_n,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic [31:0]       wbs_dat_o,
  output logic              wbs_ack_o,
  input  logic [NUM_IO-1:0] core_out,
  input  logic [NUM_IO-1:0] core_oeb,
  output logic [NUM_IO-1:0] core_in,
  input  logic [NUM_IO-1:0] io_in,
  output logic [NUM_IO-1:0] io_out,
  output logic [NUM_IO-1:0] io_oeb,
  output logic              irq
);

  localparam logic [63:0] VALID =
    (NUM_IO >= 64) ? {64{1'b1}} : ((64'd1 << NUM_IO) - 64'd1);

  logic [63:0]       gpio_sel;
  logic [63:0]       gpio_out;
  logic [63:0]       gpio_oeb;
  logic [63:0]       gpio_ien;
  logic [63:0]       gpio_istat;
  logic [NUM_IO-1:0] sync_ff [SYNC_STAGES];
  logic [NUM_IO-1:0] prev;
  logic [63:0]       in_val;
  logic [63:0]       rise;
  logic              req;
  logic              hit;
  logic              wr;
  logic [5:0]        word;
  logic [4:0]        idx;
  logic [31:0]       bmask;
  logic [63:0]       wmask;
  logic [63:0]       wdat;
  logic [63:0]       clr;
  logic [63:0]       rword;
  logic [31:0]       rdata;
  logic              unused_adr;

  function automatic logic [63:0] merge(
    input logic [63:0] old,
    input logic [63:0] m,
    input logic [63:0] d
  );
    return (old & ~m) | (d & m);
  endfunction

  assign unused_adr = ^wbs_adr_i[1:0];

  // A request is accepted only while no ack is outstanding, so a
  // master that keeps stb high sees one ack every other cycle.
  assign req   = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
  assign hit   = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign word  = wbs_adr_i[7:2];
  assign idx   = word[5:1];
  assign wr    = req & wbs_we_i & hit;
  assign bmask = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}},
                  {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
  assign wmask = (word[0] ? {bmask, 32'h0} : {32'h0, bmask}) & VALID;
  assign wdat  = {wbs_dat_i, wbs_dat_i} & wmask;
  assign clr   = (wr && idx == 5'd5) ? wdat : 64'h0;

  assign in_val = 64'(sync_ff[SYNC_STAGES-1]);
  assign rise   = in_val & ~64'(prev);

  assign core_in = io_in;
  assign io_out  = (gpio_sel[NUM_IO-1:0] & gpio_out[NUM_IO-1:0])
                 | (~gpio_sel[NUM_IO-1:0] & core_out);
  assign io_oeb  = (gpio_sel[NUM_IO-1:0] & gpio_oeb[NUM_IO-1:0])
                 | (~gpio_sel[NUM_IO-1:0] & core_oeb);

  // Read mux: pick the 64-bit register, then the addressed half.
  always_comb begin
    rword = 64'h0;
    case (idx)
      5'd0:    rword = gpio_sel;
      5'd1:    rword = gpio_out;
      5'd2:    rword = gpio_oeb;
      5'd3:    rword = in_val;
      5'd4:    rword = gpio_ien;
      5'd5:    rword = gpio_istat;
      default: rword = 64'h0;
    endcase
    rdata = word[0] ? rword[63:32] : rword[31:0];
    if (!hit) rdata = 32'h0;
  end

  // Bus handshake, registered read data and writable config registers.
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= 32'h0;
      gpio_sel  <= 64'h0;
      gpio_out  <= 64'h0;
      gpio_oeb  <= VALID;
      gpio_ien  <= 64'h0;
    end else begin
      wbs_ack_o <= req;
      wbs_dat_o <= (req && !wbs_we_i) ? rdata : 32'h0;
      if (wr) begin
        case (idx)
          5'd0:    gpio_sel <= merge(gpio_sel, wmask, wdat);
          5'd1:    gpio_out <= merge(gpio_out, wmask, wdat);
          5'd2:    gpio_oeb <= merge(gpio_oeb, wmask, wdat);
          5'd4:    gpio_ien <= merge(gpio_ien, wmask, wdat);
          default: ;
        endcase
      end
    end
  end

  // Input synchroniser chain plus the previous-value flop for edges.
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_ff[i] <= '0;
      prev <= '0;
    end else begin
      sync_ff[0] <= io_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_ff[i] <= sync_ff[i-1];
      prev <= sync_ff[SYNC_STAGES-1];
    end
  end

  // Sticky edge status; a new enabled rise beats a same-cycle clear.
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      gpio_istat <= 64'h0;
      irq        <= 1'b0;
    end else begin
      gpio_istat <= ((gpio_istat & ~clr) | (rise & gpio_ien)) & VALID;
      irq        <= |(gpio_istat & gpio_ien);
    end
  end

endmodule

// File: tb/tb_io_ctrl_wb.sv
// tb_io_ctrl_wb: scoreboard bench for io_ctrl_wb.
// Expected read data is queued at issue and popped on ack.
module tb_io_ctrl_wb;

  localparam int          N    = 38;
  localparam logic [31:0] BASE = 32'h3000_0000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cyc = 1'b0;
  logic          stb = 1'b0;
  logic          we = 1'b0;
  logic [3:0]    sel = 4'h0;
  logic [31:0]   adr = 32'h0;
  logic [31:0]   dat_w = 32'h0;
  logic [31:0]   dat_r;
  logic          ack;
  logic [N-1:0]  core_out = '0;
  logic [N-1:0]  core_oeb = '0;
  logic [N-1:0]  core_in;
  logic [N-1:0]  io_in = '0;
  logic [N-1:0]  io_out;
  logic [N-1:0]  io_oeb;
  logic          irq;

  int            n_cmp = 0;
  int            n_bad = 0;
  logic [31:0]   exp_q[$];

  io_ctrl_wb dut (
    .wb_clk_i (clk),
    .rst_n    (rst_n),
    .wbs_cyc_i(cyc),
    .wbs_stb_i(stb),
    .wbs_we_i (we),
    .wbs_sel_i(sel),
    .wbs_adr_i(adr),
    .wbs_dat_i(dat_w),
    .wbs_dat_o(dat_r),
    .wbs_ack_o(ack),
    .core_out (core_out),
    .core_oeb (core_oeb),
    .core_in  (core_in),
    .io_in    (io_in),
    .io_out   (io_out),
    .io_oeb   (io_oeb),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic bus(input logic w, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] s,
                     output logic [31:0] rd, output int lat);
    if (ack) begin
      @(posedge clk); #1;
    end
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = d; sel = s;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!ack && lat < 8);
    rd = dat_r;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] a [5];
    logic [31:0] rd, e;
    int lat;
    a = '{32'h00, 32'h10, 32'h14, 32'h28, 32'h18};
    core_out = 38'h15_5555_5555;
    core_oeb = '0;
    rst_n = 1'b0;
    settle(3);
    n_cmp++;
    if ({ack, irq, dat_r} !== 34'h0) begin
      n_bad++;
      $display("FAIL reset_bus got ack=%b irq=%b dat=%h want 0",
               ack, irq, dat_r);
    end
    n_cmp++;
    if (io_out !== 38'h15_5555_5555 || io_oeb !== '0) begin
      n_bad++;
      $display("FAIL reset_pads got out=%h oeb=%h want %h/0",
               io_out, io_oeb, 38'h15_5555_5555);
    end
    rst_n = 1'b1;
    settle(1);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'hFFFF_FFFF);
    exp_q.push_back(32'h0000_003F);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    for (int i = 0; i < 5; i++) begin
      bus(1'b0, BASE + a[i], 32'h0, 4'hF, rd, lat);
      e = exp_q.pop_front();
      n_cmp++;
      if (rd !== e || lat != 1) begin
        n_bad++;
        $display("FAIL reset_read[%0h] got %h lat %0d want %h lat 1",
                 a[i], rd, lat, e);
      end
    end
  endtask

  task automatic test_pad_mux();
    logic [31:0] a [3];
    logic [31:0] d [3];
    logic [N-1:0] m;
    logic [31:0] rd;
    int lat;
    a = '{32'h00, 32'h08, 32'h10};
    d = '{32'h0000_00FF, 32'h0000_00A5, 32'hFFFF_FF00};
    m = 38'hFF;
    core_oeb = 38'h2A_AAAA_AAAA;
    for (int i = 0; i < 3; i++) begin
      bus(1'b1, BASE + a[i], d[i], 4'hF, rd, lat);
      n_cmp++;
      if (lat != 1) begin
        n_bad++;
        $display("FAIL mux_write_lat[%0d] got %0d want 1", i, lat);
      end
    end
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (io_out !== ((core_out & ~m) | 38'hA5)) begin
        n_bad++;
        $display("FAIL mux_out[%0d] got %h want %h", k, io_out,
                 (core_out & ~m) | 38'hA5);
      end
      n_cmp++;
      if (io_oeb !== (core_oeb & ~m)) begin
        n_bad++;
        $display("FAIL mux_oeb[%0d] got %h want %h", k, io_oeb,
                 core_oeb & ~m);
      end
      core_out = 38'h2A_AAAA_AAAA;
      core_oeb = 38'h15_5555_5555;
      #1;
    end
    io_in = 38'h12_3456_789A;
    #1;
    n_cmp++;
    if (core_in !== 38'h12_3456_789A) begin
      n_bad++;
      $display("FAIL core_in got %h want %h", core_in, 38'h12_3456_789A);
    end
    io_in = '0;
    settle(6);
  endtask

  task automatic test_byte_lane();
    logic [31:0] rd, e;
    int lat;
    bus(1'b1, BASE + 32'h08, 32'h0, 4'hF, rd, lat);
    bus(1'b1, BASE + 32'h08, 32'hFFFF_FFFF, 4'b0010, rd, lat);
    exp_q.push_back(32'h0000_FF00);
    bus(1'b0, BASE + 32'h08, 32'h0, 4'hF, rd, lat);
    e = exp_q.pop_front();
    n_cmp++;
    if (rd !== e) begin
      n_bad++;
      $display("FAIL byte_lane got %h want %h", rd, e);
    end
    bus(1'b1, BASE + 32'h0C, 32'hFFFF_FFFF, 4'hF, rd, lat);
    exp_q.push_back(32'h0000_003F);
    bus(1'b0, BASE + 32'h0C, 32'h0, 4'hF, rd, lat);
    e = exp_q.pop_front();
    n_cmp++;
    if (rd !== e) begin
      n_bad++;
      $display("FAIL out_hi_mask got %h want %h", rd, e);
    end
  endtask

  task automatic test_irq();
    logic [31:0] rd, e;
    int lat;
    bus(1'b1, BASE + 32'h20, 32'h8, 4'hF, rd, lat);
    io_in[3] = 1'b1;
    settle(2);
    n_cmp++;
    if (dut.gpio_istat[3] !== 1'b0) begin
      n_bad++;
      $display("FAIL istat_early got %b want 0", dut.gpio_istat[3]);
    end
    settle(1);
    n_cmp++;
    if (dut.gpio_istat[3] !== 1'b1 || irq !== 1'b0) begin
      n_bad++;
      $display("FAIL istat_t3 got istat=%b irq=%b want 1/0",
               dut.gpio_istat[3], irq);
    end
    settle(1);
    n_cmp++;
    if (irq !== 1'b1) begin
      n_bad++;
      $display("FAIL irq_t4 got %b want 1", irq);
    end
    exp_q.push_back(32'h8);
    bus(1'b0, BASE + 32'h28, 32'h0, 4'hF, rd, lat);
    e = exp_q.pop_front();
    n_cmp++;
    if (rd !== e) begin
      n_bad++;
      $display("FAIL istat_read got %h want %h", rd, e);
    end
    bus(1'b1, BASE + 32'h28, 32'h8, 4'hF, rd, lat);
    settle(1);
    n_cmp++;
    if (irq !== 1'b0) begin
      n_bad++;
      $display("FAIL irq_after_w1c got %b want 0", irq);
    end
    io_in[3] = 1'b0;
    settle(5);
    io_in[3] = 1'b1;
    settle(6);
    io_in[3] = 1'b0;
    settle(5);
    io_in[3] = 1'b1;
    settle(2);
    bus(1'b1, BASE + 32'h28, 32'h8, 4'hF, rd, lat);
    exp_q.push_back(32'h8);
    bus(1'b0, BASE + 32'h28, 32'h0, 4'hF, rd, lat);
    e = exp_q.pop_front();
    n_cmp++;
    if (rd !== e) begin
      n_bad++;
      $display("FAIL set_beats_w1c got %h want %h", rd, e);
    end
    bus(1'b1, BASE + 32'h20, 32'h0, 4'hF, rd, lat);
    exp_q.push_back(32'h8);
    bus(1'b0, BASE + 32'h28, 32'h0, 4'hF, rd, lat);
    e = exp_q.pop_front();
    n_cmp++;
    if (rd !== e || irq !== 1'b0) begin
      n_bad++;
      $display("FAIL ien_clear got istat %h irq %b want %h irq 0",
               rd, irq, e);
    end
    bus(1'b1, BASE + 32'h28, 32'hFFFF_FFFF, 4'hF, rd, lat);
  endtask

  task automatic test_decode();
    logic [31:0] a [5];
    logic [31:0] rd, e;
    int lat;
    a = '{BASE + 32'h30, BASE + 32'h100, BASE + 32'hFC,
          BASE + 32'h08, BASE + 32'h18};
    bus(1'b1, BASE + 32'h108, 32'hFFFF_FFFF, 4'hF, rd, lat);
    bus(1'b1, BASE + 32'h18, 32'hFFFF_FFFF, 4'hF, rd, lat);
    bus(1'b1, BASE + 32'h30, 32'hFFFF_FFFF, 4'hF, rd, lat);
    io_in = '0;
    settle(4);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0000_FF00);
    exp_q.push_back(32'h0);
    for (int i = 0; i < 5; i++) begin
      bus(1'b0, a[i], 32'h0, 4'hF, rd, lat);
      e = exp_q.pop_front();
      n_cmp++;
      if (rd !== e || lat != 1) begin
        n_bad++;
        $display("FAIL decode[%h] got %h lat %0d want %h lat 1",
                 a[i], rd, lat, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] e;
    int acks;
    acks = 0;
    if (ack) settle(1);
    for (int i = 0; i < 4; i++) exp_q.push_back(32'hFFFF_FF00);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 32'h10; sel = 4'hF;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (ack !== (c % 2 == 0)) begin
        n_bad++;
        $display("FAIL b2b_ack[%0d] got %b want %b", c, ack, c % 2 == 0);
      end
      if (ack === 1'b1) begin
        acks++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
      end else begin
        e = 32'h0;
      end
      n_cmp++;
      if (dat_r !== e) begin
        n_bad++;
        $display("FAIL b2b_dat[%0d] got %h want %h", c, dat_r, e);
      end
    end
    cyc = 1'b0; stb = 1'b0;
    n_cmp++;
    if (acks != 4) begin
      n_bad++;
      $display("FAIL b2b_count got %0d want 4", acks);
    end
    exp_q.delete();
  endtask

  task automatic test_reset_mid();
    logic [31:0] a [4];
    logic [31:0] rd, e;
    int lat;
    a = '{32'h00, 32'h08, 32'h10, 32'h20};
    core_out = 38'h0F_0F0F_0F0F;
    core_oeb = 38'h30_F0F0_F0F0;
    for (int i = 0; i < 20; i++)
      bus(1'b1, BASE + a[i % 4], 32'h1357_9BDF ^ (32'(i) << 4),
          4'hF, rd, lat);
    n_cmp++;
    if (ack !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_pre_ack got %b want 1", ack);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (ack !== 1'b0 || dat_r !== 32'h0 || irq !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_async got ack=%b dat=%h irq=%b want 0",
               ack, dat_r, irq);
    end
    n_cmp++;
    if (io_out !== core_out || io_oeb !== core_oeb) begin
      n_bad++;
      $display("FAIL mid_pads got %h/%h want %h/%h",
               io_out, io_oeb, core_out, core_oeb);
    end
    settle(2);
    rst_n = 1'b1;
    settle(1);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'hFFFF_FFFF);
    exp_q.push_back(32'h0);
    for (int i = 0; i < 4; i++) begin
      bus(1'b0, BASE + a[i], 32'h0, 4'hF, rd, lat);
      e = exp_q.pop_front();
      n_cmp++;
      if (rd !== e) begin
        n_bad++;
        $display("FAIL mid_regs[%0h] got %h want %h", a[i], rd, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_pad_mux();
    test_byte_lane();
    test_irq();
    test_decode();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/io_ctrl_wb.md
Name: io_ctrl_wb

Overview:
- Parametrised pad-ownership controller between the user core and the NUM_IO user IO pads, replacing direct core-to-pad wiring in the user project wrapper.
- Each pin is driven either by the core or by a Wishbone-programmable GPIO register set.
- Adds input synchronisation, rising-edge capture and an interrupt line.
- Reset state gives the core full ownership, so legacy behaviour is unchanged until firmware reprograms it.

Parameters:
- NUM_IO, 38, number of pads controlled; legal range 1..64.
- SYNC_STAGES, 2, flop depth of the input synchroniser; legal range 2..4.
- BASE_ADDR, 32'h3000_0000, Wishbone base; decoded on adr[31:8].

Ports:
- wb_clk_i  in  1  single clock for all logic.
- rst_n  in  1  asynchronous, active-low reset.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_we_i  in  1  write enable.
- wbs_sel_i  in  4  byte lane selects.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  32  write data.
- wbs_dat_o  out  32  read data.
- wbs_ack_o  out  1  acknowledge.
- core_out  in  NUM_IO  core output values.
- core_oeb  in  NUM_IO  core output enables, active low.
- core_in  out  NUM_IO  pad inputs to the core; equals io_in combinationally, unsynchronised.
- io_in  in  NUM_IO  pad inputs.
- io_out  out  NUM_IO  pad outputs.
- io_oeb  out  NUM_IO  pad output enables, active low.
- irq  out  1  level interrupt.

Behaviour:
- Register map (offset from BASE_ADDR; LO = pins 31..0, HI = pins 63..32):
  - 0x00/0x04 SEL: 1 = GPIO owns the pin, 0 = core owns it.
  - 0x08/0x0C OUT.
  - 0x10/0x14 OEB.
  - 0x18/0x1C IN, read-only, synchronised value.
  - 0x20/0x24 IEN.
  - 0x28/0x2C ISTAT, W1C.
  - Offsets 0x30..0xFF read 0; writes to them are ignored.
- Bits at index >= NUM_IO read 0 and ignore writes.
- Pad mux (combinational): io_out[i] = SEL[i] ? OUT[i] : core_out[i]; io_oeb[i] = SEL[i] ? OEB[i] : core_oeb[i].
- Reset values:
  - SEL=0, OUT=0, OEB=all 1, IEN=0, ISTAT=0.
  - Synchroniser and edge flops = 0.
  - wbs_ack_o=0, wbs_dat_o=0, irq=0.
  - After reset, io_out/io_oeb equal core_out/core_oeb.
- Wishbone handshake:
  - ack asserts exactly 1 cycle after the first edge where cyc&stb&!ack.
  - ack is a single-cycle pulse.
  - A master holding stb gets one ack every 2 cycles.
  - An address outside BASE_ADDR[31:8] is still acked, reads 0 and writes nothing; the bus must never hang.
- Writes:
  - Registers update on the ack cycle edge.
  - Only byte lanes with wbs_sel_i set are written.
  - IN writes are ignored.
  - ISTAT write: each 1 bit clears; 0 bits are unaffected.
- Reads: wbs_dat_o is registered, valid while ack=1, and 0 otherwise.
- Input path: io_in passes through SYNC_STAGES flops to give IN.
- Edge capture:
  - One further flop holds prev.
  - rise[i] = IN[i] & !prev[i].
  - ISTAT[i] sets when rise[i] & IEN[i].
  - Latency: a pad rising edge appears in ISTAT SYNC_STAGES+1 cycles later.
- Simultaneous W1C and new rise on the same bit: set wins; bit stays 1.
- Clearing IEN does not clear ISTAT.
- irq = |(ISTAT & IEN), registered; it follows ISTAT/IEN by 1 cycle.
- Reset mid-transaction: ack and dat_o drop immediately (asynchronously). A pending write is discarded. The master must restart.

Test Plan:
- Reset, drive core_out=38'h15_5555_5555 and core_oeb=0 -> io_out=38'h15_5555_5555, io_oeb=0; reads of SEL_LO and OEB_LO return 0 and 32'hFFFF_FFFF.
- Write SEL_LO=32'h0000_00FF, OUT_LO=32'h0000_00A5, OEB_LO=32'hFFFF_FF00 -> io_out[7:0]=8'hA5, io_oeb[7:0]=0, pins 8..37 still follow core; each write acks exactly 1 cycle after stb.
- Byte-lane write: sel=4'b0010, dat=32'hFFFF_FFFF to OUT_LO after it holds 0 -> read returns 32'h0000_FF00.
- IEN_LO=1<<3, raise io_in[3] at cycle T -> ISTAT_LO bit3=1 at T+3, irq=1 at T+4; writing ISTAT_LO=8 -> irq=0 next cycle. A second rise landing on the W1C cycle leaves bit3=1.
- Read 0x30 and BASE_ADDR+0x100 -> both ack with 0. Write OUT_HI=32'hFFFF_FFFF -> reads 32'h0000_003F (NUM_IO=38).
- Assert rst_n low while ack=1 after 20 writes -> ack=0 at once; all registers are at reset values; io_out again equals core_out.
